// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding,
// default fault instruction and the decode-side payload layout.
package inst_fetch_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_WAIT = 2'd1;
  localparam logic [STATE_W-1:0] ST_HOLD = 2'd2;
  localparam logic [STATE_W-1:0] ST_DROP = 2'd3;

  localparam logic [XLEN-1:0] NOP_INST_DEFAULT = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
    logic            misalign;
  } id_payload_t;

endpackage

// File: rtl/inst_fetch.sv
// Single-outstanding instruction fetch: takes a PC, issues one memory request,
// and holds the returned instruction for decode until consumed or flushed.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_misalign,
  input  logic        id_ready,
  output logic [31:0] fetch_cnt
);

  logic [STATE_W-1:0] state_q, state_nxt;
  logic               req_q, req_nxt;
  logic [XLEN-1:0]    addr_q, addr_nxt;
  logic               valid_q, valid_nxt;
  id_payload_t        id_q, id_nxt;
  logic [XLEN-1:0]    cnt_q, cnt_nxt;
  logic               accept;

  assign pc_ready = !flush && ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && id_ready));
  assign accept   = pc_valid && pc_ready;

  // Next-state and next-output logic; imem_addr doubles as the latched PC.
  always_comb begin
    state_nxt = state_q;
    req_nxt   = req_q;
    addr_nxt  = addr_q;
    valid_nxt = valid_q;
    id_nxt    = id_q;
    cnt_nxt   = cnt_q;

    case (state_q)
      ST_IDLE: ;
      ST_WAIT: begin
        if (imem_ack) begin
          req_nxt = 1'b0;
          if (flush) begin
            state_nxt = ST_IDLE;
          end else begin
            valid_nxt       = 1'b1;
            id_nxt.pc       = addr_q;
            id_nxt.inst     = imem_rdata;
            id_nxt.misalign = 1'b0;
            cnt_nxt         = cnt_q + XLEN'(1);
            state_nxt       = ST_HOLD;
          end
        end else if (flush) begin
          state_nxt = ST_DROP;
        end
      end
      ST_DROP: begin
        if (imem_ack) begin
          req_nxt   = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (flush || id_ready) begin
          valid_nxt = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Accept overrides HOLD's consume path so back-to-back issue works.
    if (accept) begin
      if (pc_i[1:0] == 2'b00) begin
        req_nxt   = 1'b1;
        addr_nxt  = pc_i;
        valid_nxt = 1'b0;
        state_nxt = ST_WAIT;
      end else begin
        valid_nxt       = 1'b1;
        id_nxt.pc       = pc_i;
        id_nxt.inst     = NOP_INST;
        id_nxt.misalign = 1'b1;
        state_nxt       = ST_HOLD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      id_q    <= '{pc: '0, inst: NOP_INST, misalign: 1'b0};
      cnt_q   <= '0;
    end else begin
      state_q <= state_nxt;
      req_q   <= req_nxt;
      addr_q  <= addr_nxt;
      valid_q <= valid_nxt;
      id_q    <= id_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign id_valid    = valid_q;
  assign id_pc       = id_q.pc;
  assign id_inst     = id_q.inst;
  assign id_misalign = id_q.misalign;
  assign fetch_cnt   = cnt_q;

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter NOP_INST, default 32'h0000_0013, instruction word presented with a misaligned-PC fault.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  asynchronous reset, active-low (0 = reset).
REQ-004 pc_i  in  32  fetch address from the PC stage.
REQ-005 pc_valid  in  1  pc_i valid this cycle.
REQ-006 pc_ready  out  1  block accepts pc_i this cycle.
REQ-007 flush  in  1  jump/redirect; kills any in-flight or held fetch.
REQ-008 imem_req  out  1  instruction memory request.
REQ-009 imem_addr  out  32  request address.
REQ-010 imem_ack  in  1  memory returns data this cycle.
REQ-011 imem_rdata  in  32  returned instruction, valid with imem_ack.
REQ-012 id_valid  out  1  decode-side output valid.
REQ-013 id_pc  out  32  PC of id_inst.
REQ-014 id_inst  out  32  fetched instruction.
REQ-015 id_misalign  out  1  pc_i[1:0] != 0 fault flag for this output.
REQ-016 id_ready  in  1  decode consumes the output this cycle.
REQ-017 fetch_cnt  out  32  count of completed, non-discarded fetches; wraps at 2^32.

Function
REQ-018 FSM states: IDLE, WAIT, HOLD, DROP; all outputs registered except pc_ready.
REQ-019 pc_ready = !flush & (state==IDLE | (state==HOLD & id_ready)).
REQ-020 Accept (pc_valid & pc_ready), aligned: next cycle imem_req=1, imem_addr=pc_i, PC latched; state -> WAIT.
REQ-021 Accept, misaligned: no memory request; next cycle id_valid=1, id_inst=NOP_INST, id_misalign=1, id_pc=pc_i; state -> HOLD.
REQ-022 WAIT: imem_req and imem_addr held stable until imem_ack; variable latency, no timeout.
REQ-023 WAIT, imem_ack & !flush: next cycle imem_req=0, id_valid=1, id_inst=imem_rdata, id_misalign=0, fetch_cnt+1; state -> HOLD.
REQ-024 WAIT, flush & !imem_ack: state -> DROP; imem_req stays 1 until ack.
REQ-025 WAIT, flush & imem_ack same cycle: data discarded, imem_req=0, state -> IDLE, fetch_cnt unchanged.
REQ-026 DROP: flush ignored; on imem_ack data discarded, imem_req=0, state -> IDLE.
REQ-027 HOLD: id_valid, id_pc, id_inst, id_misalign stable until id_ready or flush.
REQ-028 HOLD, id_ready & !flush & !pc_valid: id_valid=0 next cycle, state -> IDLE.
REQ-029 HOLD, id_ready & pc_valid & !flush: back-to-back; output consumed and new PC accepted same cycle per REQ-020/021.
REQ-030 HOLD, flush (regardless of id_ready): id_valid=0 next cycle, state -> IDLE.
REQ-031 Latency: accept at cycle t, ack at cycle t+k (k>=1) -> id_valid at t+k+1; misaligned -> id_valid at t+1.
REQ-032 Misaligned faults do not increment fetch_cnt.

Reset
REQ-033 rst=0 forces asynchronously: state IDLE, imem_req=0, imem_addr=0, id_valid=0, id_pc=0, id_inst=NOP_INST, id_misalign=0, fetch_cnt=0.
REQ-034 Reset mid-WAIT abandons the request; a later stray imem_ack in IDLE is ignored.

Structure
REQ-035 Shared package holds the FSM state encoding (2-bit) and the NOP_INST default constant.
REQ-036 Single flat module; no sub-modules.

Verification
REQ-037 Reset, pc_i=0x100 valid, ack after 3 cycles with 0x00A00093, id_ready=1 -> id_valid one cycle after ack, id_pc=0x100, id_inst=0x00A00093, fetch_cnt=1.
REQ-038 pc_i=0x102 valid -> no imem_req, next cycle id_valid=1, id_inst=0x00000013, id_misalign=1, fetch_cnt=0.
REQ-039 Accept 0x200, flush in WAIT, ack 2 cycles later -> DROP, data discarded, id_valid never 1, returns to IDLE, fetch_cnt unchanged.
REQ-040 Flush and ack same cycle in WAIT -> IDLE next cycle, id_valid=0, imem_req=0.
REQ-041 HOLD with id_ready=0 for 4 cycles -> outputs stable; then id_ready=1 with pc_valid=1, pc_i=0x104 -> pc_ready=1 that cycle and imem_req=1, imem_addr=0x104 next cycle.
REQ-042 rst=0 asserted mid-WAIT -> all outputs reset immediately; ack arriving in IDLE produces no output.
